psum_collector: RTL and testbench

PSUM_COLLECTOR -- requirements
Module: psum_collector

---
 rtl/psum_collector.sv | 137 +++++++++++++
 tb/tb_psum_collector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// Psum collector: deskews the staggered bottom-row psum columns of a systolic array
// and buffers the complete rows in a small FIFO that drains under valid/ready.

module psum_deskew_lane #(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  vin,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  vout
);
    generate
        if (STAGES == 0) begin : g_pass
            logic lane_unused;
            assign lane_unused = ^{clk, rst, clear};
            assign dout = din;
            assign vout = vin;
        end else begin : g_dly
            logic [STAGES-1:0]                 vld_pipe;
            logic [STAGES-1:0][DATA_WIDTH-1:0] dat_pipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else if (clear) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= vin;
                    dat_pipe[0] <= din;
                    for (int s = 1; s < STAGES; s++) begin
                        vld_pipe[s] <= vld_pipe[s-1];
                        dat_pipe[s] <= dat_pipe[s-1];
                    end
                end
            end

            assign dout = dat_pipe[STAGES-1];
            assign vout = vld_pipe[STAGES-1];
        end
    endgenerate
endmodule

module psum_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int COLS       = 2,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic [COLS*DATA_WIDTH-1:0] psum_in,
    input  logic [COLS-1:0]            psum_valid_in,
    output logic [COLS*DATA_WIDTH-1:0] out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       skew_error
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [COLS-1:0][DATA_WIDTH-1:0] dly_data;
    logic [COLS-1:0]                 dly_vld;

    // Column c waits COLS-1-c cycles so every lane lines up with the last column.
    generate
        for (genvar c = 0; c < COLS; c++) begin : g_lane
            psum_deskew_lane #(
                .DATA_WIDTH(DATA_WIDTH),
                .STAGES    (COLS-1-c)
            ) u_lane (
                .clk  (clk),
                .rst  (rst),
                .clear(clear),
                .din  (psum_in[c*DATA_WIDTH +: DATA_WIDTH]),
                .vin  (psum_valid_in[c]),
                .dout (dly_data[c]),
                .vout (dly_vld[c])
            );
        end
    endgenerate

    logic [COLS*DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic                       aligned_valid, aligned_any, full, push, pop, drop, skew;

    assign aligned_valid = &dly_vld;
    assign aligned_any   = |dly_vld;
    assign full          = (count == FULL_CNT);
    assign out_valid     = (count != '0);
    assign pop           = out_valid & out_ready;
    // A pop in the same edge frees the slot, so a full FIFO still accepts the push.
    assign push          = aligned_valid & (~full | pop);
    assign drop          = aligned_valid & full & ~pop;
    assign skew          = aligned_any & ~aligned_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            skew_error <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            skew_error <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) overflow   <= 1'b1;
            if (skew) skew_error <= 1'b1;
        end
    end

    // Row storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= dly_data;
    end

    assign out_data = out_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_psum_collector.sv
// Randomized and directed bench for psum_collector (COLS=2, DEPTH=4, DATA_WIDTH=16)
// against a queue-based row model.

module tb_psum_collector;
    localparam int DW = 16, COLS = 2, DEPTH = 4;

    logic              clk, rst, clear, out_valid, out_ready, overflow, skew_error;
    logic [COLS*DW-1:0] psum_in, out_data;
    logic [COLS-1:0]    psum_valid_in;
    logic [2:0]         count;

    int n_cmp = 0, n_bad = 0;

    // Model: col0 seen last cycle, queue of buffered rows, sticky flags.
    bit          pv0;
    logic [15:0] pd0;
    logic [31:0] mq[$];
    bit          m_ovf, m_skew;

    psum_collector #(.DATA_WIDTH(DW), .COLS(COLS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .psum_in(psum_in),
        .psum_valid_in(psum_valid_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .overflow(overflow), .skew_error(skew_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_skew = 0; pv0 = 0; pd0 = '0;
    endtask

    function automatic logic [37:0] exp_vec();
        logic [31:0] head = (mq.size() > 0) ? mq[0] : 32'h0;
        return {mq.size() > 0, head, 3'(mq.size()), m_ovf, m_skew};
    endfunction

    function automatic logic [37:0] act_vec();
        return {out_valid, out_data, count, overflow, skew_error};
    endfunction

    // One clock: drive inputs, advance the model, then sample 1ns after the edge.
    task automatic cyc(input bit v0, input logic [15:0] d0, input bit v1,
                       input logic [15:0] d1, input bit rdy, input bit clr);
        psum_valid_in = {v1, v0};
        psum_in       = {d1, d0};
        out_ready     = rdy;
        clear         = clr;
        if (clr) begin
            model_reset();
        end else begin
            bit all_v = pv0 && v1;
            bit any_v = pv0 || v1;
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (all_v) begin
                if (mq.size() < DEPTH) mq.push_back({d1, pd0});
                else m_ovf = 1;
            end
            if (any_v && !all_v) m_skew = 1;
            pv0 = v0; pd0 = d0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 16'h0, 0, 16'h0, rdy, 0);
    endtask

    task automatic test_reset();
        rst = 1; clear = 0; out_ready = 0; psum_in = '0; psum_valid_in = '0;
        #3;
        n_cmp++;
        if (act_vec() !== 38'h0) begin
            n_bad++; $display("FAIL reset_async: got %h expected 0", act_vec());
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (act_vec() !== 38'h0) begin
            n_bad++; $display("FAIL reset_held: got %h expected 0", act_vec());
        end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_single_row();
        cyc(1, 16'h0100, 0, 16'h0, 1, 0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_early: out_valid %b expected 0", out_valid);
        end
        cyc(0, 16'h0, 1, 16'h0200, 1, 0);
        n_cmp++;
        if ({out_valid, out_data, count} !== {1'b1, 32'h0200_0100, 3'd1}) begin
            n_bad++; $display("FAIL single_row: got v=%b d=%h c=%0d expected v=1 d=02000100 c=1",
                              out_valid, out_data, count);
        end
        idle(1);
        n_cmp++;
        if (act_vec() !== exp_vec() || count !== 3'd0) begin
            n_bad++; $display("FAIL single_drain: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r[16];
        for (int i = 0; i < 16; i++) r[i] = $urandom;
        for (int k = 0; k <= 5; k++) begin
            logic [31:0] cur = (k < 5) ? r[k] : 32'h0;
            logic [31:0] prv = (k > 0) ? r[k-1] : 32'h0;
            cyc(k < 5, cur[15:0], k > 0, prv[31:16], 0, 0);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL bp_fill%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({count, overflow} !== {3'd4, 1'b1}) begin
            n_bad++; $display("FAIL bp_full: count %0d ovf %b expected 4 1", count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_data !== r[i] || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_drain%0d: got %h expected %h", i, out_data, r[i]);
            end
            idle(1);
        end
        n_cmp++;
        if (count !== 3'd0) begin
            n_bad++; $display("FAIL bp_empty: count %0d expected 0", count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] r[16];
        logic [31:0] nr = $urandom;
        logic [31:0] want;
        for (int i = 0; i < 16; i++) r[i] = $urandom;
        cyc(0, 16'h0, 0, 16'h0, 0, 1);
        n_cmp++;
        if ({count, overflow, skew_error} !== 5'b0) begin
            n_bad++; $display("FAIL fpp_clear: c=%0d o=%b s=%b expected 0", count, overflow, skew_error);
        end
        for (int k = 0; k <= 4; k++) begin
            logic [31:0] cur = (k < 4) ? r[k] : 32'h0;
            logic [31:0] prv = (k > 0) ? r[k-1] : 32'h0;
            cyc(k < 4, cur[15:0], k > 0, prv[31:16], 0, 0);
        end
        cyc(1, nr[15:0], 0, 16'h0, 0, 0);
        cyc(0, 16'h0, 1, nr[31:16], 1, 0);
        n_cmp++;
        if ({count, overflow} !== {3'd4, 1'b0}) begin
            n_bad++; $display("FAIL fpp_full: count %0d ovf %b expected 4 0", count, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            want = (i < 3) ? r[i+1] : nr;
            n_cmp++;
            if (out_data !== want) begin
                n_bad++; $display("FAIL fpp_drain%0d: got %h expected %h", i, out_data, want);
            end
            idle(1);
        end
    endtask

    task automatic test_skew();
        logic [31:0] r = $urandom;
        cyc(0, 16'h0, 0, 16'h0, 0, 1);
        cyc(1, 16'hbeef, 0, 16'h0, 1, 0);
        idle(1);
        n_cmp++;
        if ({skew_error, count, overflow} !== {1'b1, 3'd0, 1'b0}) begin
            n_bad++; $display("FAIL skew_flag: s=%b c=%0d expected s=1 c=0", skew_error, count);
        end
        cyc(1, r[15:0], 0, 16'h0, 0, 0);
        cyc(0, 16'h0, 1, r[31:16], 0, 0);
        n_cmp++;
        if ({out_valid, out_data, skew_error} !== {1'b1, r, 1'b1}) begin
            n_bad++; $display("FAIL skew_recover: got %h expected %h", out_data, r);
        end
        idle(1);
    endtask

    task automatic test_wrap();
        logic [31:0] r[16];
        logic [31:0] got[$];
        for (int i = 0; i < 16; i++) r[i] = $urandom;
        cyc(0, 16'h0, 0, 16'h0, 0, 1);
        for (int k = 0; k < 30; k++) begin
            bit rdy = (k % 2) == 0;
            int j = k / 2;
            bit snd = j < 10;
            if (out_valid && rdy) got.push_back(out_data);
            if (k % 2 == 0) cyc(snd, r[j][15:0], 0, 16'h0, rdy, 0);
            else            cyc(0, 16'h0, snd, r[j][31:16], rdy, 0);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL wrap_cyc%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (got.size() != 10) begin
            n_bad++; $display("FAIL wrap_count: got %0d rows expected 10", got.size());
        end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            n_cmp++;
            if (got[i] !== r[i]) begin
                n_bad++; $display("FAIL wrap_row%0d: got %h expected %h", i, got[i], r[i]);
            end
        end
    endtask

    task automatic test_random();
        bit lv0 = 0;
        for (int k = 0; k < 400; k++) begin
            bit v0  = ($urandom % 3) != 0;
            bit v1  = (($urandom % 10) == 0) ? !lv0 : lv0;
            bit clr = ($urandom % 50) == 0;
            cyc(v0, 16'($urandom), v1, 16'($urandom), 1'($urandom), clr);
            lv0 = clr ? 1'b0 : v0;
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL rand_cyc%0d: got %h expected %h", k, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_clear();
        logic [31:0] r[16];
        for (int i = 0; i < 16; i++) r[i] = $urandom;
        cyc(0, 16'h0, 0, 16'h0, 0, 1);
        for (int k = 0; k <= 3; k++) begin
            logic [31:0] cur = (k < 3) ? r[k] : 32'h0;
            logic [31:0] prv = (k > 0) ? r[k-1] : 32'h0;
            cyc(k < 3, cur[15:0], k > 0, prv[31:16], 0, 0);
        end
        n_cmp++;
        if (count !== 3'd3) begin
            n_bad++; $display("FAIL rc_fill: count %0d expected 3", count);
        end
        #2 rst = 1;
        #1;
        n_cmp++;
        if (act_vec() !== 38'h0) begin
            n_bad++; $display("FAIL rc_async_rst: got %h expected 0", act_vec());
        end
        psum_valid_in = '0;
        @(negedge clk);
        rst = 0;
        model_reset();
        for (int k = 0; k <= 5; k++) begin
            logic [31:0] cur = (k < 5) ? r[k+3] : 32'h0;
            logic [31:0] prv = (k > 0) ? r[k+2] : 32'h0;
            cyc(k < 5, cur[15:0], k > 0, prv[31:16], 0, 0);
        end
        cyc(1, 16'h1234, 0, 16'h0, 0, 0);
        cyc(1, 16'h5678, 0, 16'h0, 0, 0);
        n_cmp++;
        if ({count, overflow, skew_error} !== {3'd4, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL rc_flags: c=%0d o=%b s=%b expected 4 1 1", count, overflow, skew_error);
        end
        cyc(0, 16'h0, 1, 16'h9abc, 1, 1);
        n_cmp++;
        if (act_vec() !== 38'h0) begin
            n_bad++; $display("FAIL rc_clear: got %h expected 0", act_vec());
        end
        idle(0);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL rc_post_clear: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_full_push_pop();
        test_skew();
        test_wrap();
        test_random();
        test_reset_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
